// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Sits between the TinyALU pins and the actual-result path of the checker.
//   It pairs every command on the DUT bus with its result. It buffers the
//   paired record in a small first-word-fall-through FIFO and presents the
//   record on a valid/ready stream. It also flags these protocol problems:
//   done with no command outstanding, a command that never completes, and a
//   record lost to a full buffer.
//
// Ports
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   A, B, op, start      DUT command bus (op 0 = no_op, start held until done)
//   done, result         DUT response (result valid while done=1)
//   out_valid/out_ready  record stream handshake, pop on valid && ready
//   out_data             head record {op, A, B, result}
//   count                FIFO occupancy, 0..DEPTH
//   err_unexpected_done  one-cycle pulse: done seen in IDLE or RELEASE
//   err_timeout          one-cycle pulse: command abandoned after TIMEOUT cycles
//   overflow             sticky: a record was dropped because the FIFO was full
module alu_result_collector #(
  parameter int DEPTH   = 8,   // power of two, >= 2
  parameter int TIMEOUT = 64   // >= 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               A,
  input  logic [7:0]               B,
  input  logic [2:0]               op,
  input  logic                     start,
  input  logic                     done,
  input  logic [15:0]              result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [34:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_unexpected_done,
  output logic                     err_timeout,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t          state;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   tmo_cnt;

  // --------------------------------------------------------------------------
  // Command / response FSM
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      a_q                 <= '0;
      b_q                 <= '0;
      op_q                <= '0;
      tmo_cnt             <= '0;
      err_timeout         <= 1'b0;
      err_unexpected_done <= 1'b0;
    end else begin
      err_timeout         <= 1'b0;
      err_unexpected_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (done) err_unexpected_done <= 1'b1;
          if (start) begin
            if (op != 3'd0) begin
              a_q     <= A;
              b_q     <= B;
              op_q    <= op;
              tmo_cnt <= '0;
              state   <= S_BUSY;
            end else begin
              // no_op completes immediately; the record is pushed this edge
              state <= S_RELEASE;
            end
          end
        end
        S_BUSY: begin
          // done wins over the timeout if both land on the same edge
          if (done) begin
            state <= S_RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (done) err_unexpected_done <= 1'b1;
          // start must drop before another command is accepted
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Record assembly
  // --------------------------------------------------------------------------
  logic        push_req;
  logic [34:0] push_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE: begin
        if (start && op == 3'd0) begin
          push_req  = 1'b1;
          push_data = {3'd0, A, B, 16'h0000};
        end
      end
      S_BUSY: begin
        if (done) begin
          push_req  = 1'b1;
          push_data = {op_q, a_q, b_q, result};  // operands from the latch
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Record FIFO (first-word-fall-through from registered storage)
  // --------------------------------------------------------------------------
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          do_push;

  assign full    = (count == FULL_CNT);
  assign pop     = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; nothing reads an entry before it
  // is written, because out_data is gated with out_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- RTL-side collector between the TinyALU DUT pins and the actual-result path of the checker.
- Watches the DUT command bus (A, B, op, start) and its response (done, result).
- Pairs each command with its result, buffers the record in a small FIFO, and presents it on a valid/ready stream to the transaction side. That side converts each record to an alu_result object and puts it into the actual-result FIFO.
- Also flags protocol violations: unexpected done, command timeout and buffer overflow.

Parameters:
- DEPTH, 8: record FIFO entries; power of two, at least 2.
- TIMEOUT, 64: maximum cycles in BUSY before the command is abandoned; at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- A  in  8  DUT operand A.
- B  in  8  DUT operand B.
- op  in  3  DUT opcode; 0 = no_op.
- start  in  1  DUT start; held high by the driver until done.
- done  in  1  DUT done pulse.
- result  in  16  DUT result; valid when done=1.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_data  out  35  head record = {op[2:0], A[7:0], B[7:0], result[15:0]}.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- err_unexpected_done  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.
- overflow  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: asserting reset_n=0 immediately forces the following, regardless of clk:
  - FSM goes to IDLE; FIFO is emptied.
  - out_valid=0, out_data=0, count=0.
  - All error outputs = 0; the timeout counter = 0.
  - Any in-flight command is discarded.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE with start=1 and op≠0:
  - Latch A, B and op; clear the timeout counter; go to BUSY.
- IDLE with start=1 and op=0 (no_op):
  - Push {0, A, B, 16'h0000}; go to RELEASE. No done is expected.
- BUSY with done=1:
  - Push {latched op, latched A, latched B, result}; go to RELEASE.
  - Operands are taken from the latch, not the live bus.
- BUSY with done=0:
  - Increment the counter.
  - When the counter reaches TIMEOUT-1 without done, pulse err_timeout next cycle, push nothing, go to RELEASE.
- RELEASE: wait for start=0, then go to IDLE.
  - A new command needs start low for at least one cycle after completion.
  - Start held high continuously is not a second command.
- done=1 in IDLE or RELEASE: pulse err_unexpected_done on the next cycle; no push; state unchanged.
- Latency: a record pushed on edge N is visible on out_valid/out_data after edge N. A one-cycle done gives out_valid=1 in the cycle following done.
- FIFO and stream:
  - First-word-fall-through, registered.
  - Pop occurs when out_valid && out_ready at the edge.
  - out_data must be stable while out_valid=1 and out_ready=0.
- Full FIFO with a push and no pop: the record is dropped, overflow is set, FIFO contents are unchanged.
- Full FIFO with a push and a pop on the same edge: both succeed; count stays DEPTH; no overflow.
- Empty FIFO with a push and out_ready=1: no pop (out_valid was 0); count becomes 1.
- Pointers wrap modulo DEPTH; count is a separate counter with range 0 to DEPTH.

Test Plan:
1. Single command A=8'hFF, B=8'h02, op=3'b001 (add); DUT returns done with result=16'h0101 → one cycle later out_valid=1, out_data={3'b001, 8'hFF, 8'h02, 16'h0101}; count=1; pop → count=0.
2. Live-bus independence: A=3, B=4, op=3'b011 (mul) held for 3 cycles, then A/B change while BUSY; done with result=12 → record carries A=3, B=4, result=12.
3. no_op: start with op=0, A=5, B=6, no done → record {0, 5, 6, 0} pushed; start held high 4 more cycles → no further records.
4. Timeout with TIMEOUT=8: start with op=add and done never asserted → err_timeout pulses once at cycle 8; no record; then start=0 returns FSM to IDLE; done in IDLE → err_unexpected_done pulse.
5. Backpressure, DEPTH=4: out_ready=0 and 5 commands → count=4, overflow=1, first 4 records in order; then push and pop on the same edge with the FIFO full → count stays 4, overflow unchanged.
6. Async reset while BUSY with 2 records queued → out_valid=0, count=0, overflow=0 immediately; a subsequent done is flagged as unexpected.
